// File: rtl/piyc_pkg.sv
// Shared encodings for the PIYC accumulator machine: opcodes, host modes and
// status bit positions on uio_out.
package piyc_pkg;

    localparam int unsigned MemDepth = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_IN   = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_LDH  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_SWAP = 4'hC;
    localparam logic [3:0] OP_NOT  = 4'hD;
    localparam logic [3:0] OP_INC  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    localparam int unsigned STAT_RUNNING = 0;
    localparam int unsigned STAT_C       = 1;
    localparam int unsigned STAT_Z       = 2;
    localparam int unsigned STAT_HALTED  = 3;

endpackage

// File: rtl/piyc_strobe_sync.sv
// Two-flop synchroniser for the host strobe plus a one-cycle rising-edge pulse.
module piyc_strobe_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic pulse_o
);

    logic s1_q, s2_q, s3_q;

    // Runs regardless of the tile enable so a strobe is never half-captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= strobe_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/tt_um_romartino_piyc.sv
// PIYC tile top: 16-byte program memory, 8-bit accumulator datapath and the
// load/run/step control driven by the host mode bits.
module tt_um_romartino_piyc
    import piyc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] mem_q [MemDepth];
    logic [3:0] pc_q, pc_d;
    logic [7:0] acc_q, acc_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       halted_q, halted_d;
    logic [7:0] out_q, out_d;
    logic [3:0] wptr_q, wptr_d;
    logic [1:0] mode_prev_q, mode_prev_d;

    logic [1:0] mode;
    logic       pulse;
    logic       exec;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] instr;
    logic [3:0] op, imm;
    logic       upd_z;
    logic       unused_ok;

    assign mode      = uio_in[7:6];
    assign unused_ok = ^uio_in[4:0];

    piyc_strobe_sync u_strobe_sync (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .strobe_i(uio_in[5]),
        .pulse_o (pulse)
    );

    assign instr = mem_q[pc_q];
    assign op    = instr[7:4];
    assign imm   = instr[3:0];

    always_comb begin
        pc_d        = pc_q;
        acc_d       = acc_q;
        z_d         = z_q;
        c_d         = c_q;
        halted_d    = halted_q;
        out_d       = out_q;
        wptr_d      = wptr_q;
        mode_prev_d = mode_prev_q;
        mem_we      = 1'b0;
        mem_waddr   = wptr_q;
        exec        = 1'b0;
        upd_z       = 1'b0;

        if (ena) begin
            mode_prev_d = mode;
            unique case (mode)
                MODE_IDLE: ;
                MODE_LOAD: begin
                    pc_d     = '0;
                    acc_d    = '0;
                    z_d      = 1'b0;
                    c_d      = 1'b0;
                    halted_d = 1'b0;
                    // Write pointer restarts whenever LOAD is freshly entered.
                    mem_waddr = (mode_prev_q != MODE_LOAD) ? 4'd0 : wptr_q;
                    wptr_d    = mem_waddr;
                    if (pulse) begin
                        mem_we = 1'b1;
                        wptr_d = mem_waddr + 4'd1;
                    end
                end
                MODE_RUN:  exec = ~halted_q;
                MODE_STEP: exec = pulse & ~halted_q;
            endcase
        end

        if (exec) begin
            pc_d = pc_q + 4'd1;
            unique case (op)
                OP_NOP:  ;
                OP_LDI:  begin acc_d = {4'h0, imm}; upd_z = 1'b1; end
                OP_ADDI: begin {c_d, acc_d} = {1'b0, acc_q} + {5'b0, imm}; upd_z = 1'b1; end
                OP_SUBI: begin
                    acc_d = acc_q - {4'h0, imm};
                    c_d   = acc_q < {4'h0, imm};
                    upd_z = 1'b1;
                end
                OP_IN:   begin acc_d = ui_in; upd_z = 1'b1; end
                OP_OUT:  out_d = acc_q;
                OP_SHL:  begin c_d = acc_q[7]; acc_d = {acc_q[6:0], 1'b0}; upd_z = 1'b1; end
                OP_SHR:  begin c_d = acc_q[0]; acc_d = {1'b0, acc_q[7:1]}; upd_z = 1'b1; end
                OP_LDH:  begin acc_d = {imm, acc_q[3:0]}; upd_z = 1'b1; end
                OP_JMP:  pc_d = imm;
                OP_JZ:   if (z_q) pc_d = imm;
                OP_JC:   if (c_q) pc_d = imm;
                OP_SWAP: begin acc_d = {acc_q[3:0], acc_q[7:4]}; upd_z = 1'b1; end
                OP_NOT:  begin acc_d = ~acc_q; upd_z = 1'b1; end
                OP_INC:  begin {c_d, acc_d} = {1'b0, acc_q} + 9'd1; upd_z = 1'b1; end
                OP_HLT:  begin halted_d = 1'b1; pc_d = pc_q; end
            endcase
            if (upd_z) z_d = (acc_d == 8'h00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MemDepth; i++) mem_q[i] <= '0;
            pc_q        <= '0;
            acc_q       <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            halted_q    <= 1'b0;
            out_q       <= '0;
            wptr_q      <= '0;
            mode_prev_q <= MODE_IDLE;
        end else begin
            if (mem_we) mem_q[mem_waddr] <= ui_in;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            c_q         <= c_d;
            halted_q    <= halted_d;
            out_q       <= out_d;
            wptr_q      <= wptr_d;
            mode_prev_q <= mode_prev_d;
        end
    end

    always_comb begin
        uio_out               = 8'h00;
        uio_out[STAT_HALTED]  = halted_q;
        uio_out[STAT_Z]       = z_q;
        uio_out[STAT_C]       = c_q;
        uio_out[STAT_RUNNING] = (mode == MODE_RUN) & ~halted_q;
    end

    assign uo_out = out_q;
    assign uio_oe = 8'h0F;

endmodule

// File: tb/tb_tt_um_romartino_piyc.sv
// Directed and randomized bench for the PIYC tile against an instruction-level model.
module tb_tt_um_romartino_piyc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       strobe = 1'b0;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    assign uio_in = {mode, strobe, 5'b0};

    tt_um_romartino_piyc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instruction-level model of the machine.
    logic [7:0] m_mem [16];
    int         m_pc, m_acc, m_out, m_wp;
    bit         m_z, m_c, m_halt;
    logic [1:0] m_prev;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_pc = 0; m_acc = 0; m_out = 0; m_wp = 0;
        m_z = 0; m_c = 0; m_halt = 0;
        m_prev = 2'b00;
    endtask

    task automatic m_exec();
        int ins, op, imm, r, next_pc;
        ins = int'(m_mem[m_pc]);
        op = ins / 16;
        imm = ins % 16;
        next_pc = (m_pc + 1) % 16;
        case (op)
            1: m_acc = imm;
            2: begin r = m_acc + imm; m_c = (r > 255); m_acc = r % 256; end
            3: begin m_c = (m_acc < imm); m_acc = (m_acc - imm + 256) % 256; end
            4: m_acc = int'(ui_in);
            5: m_out = m_acc;
            6: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
            7: begin m_c = ((m_acc % 2) == 1); m_acc = m_acc / 2; end
            8: m_acc = imm * 16 + m_acc % 16;
            9: next_pc = imm;
            10: if (m_z) next_pc = imm;
            11: if (m_c) next_pc = imm;
            12: m_acc = (m_acc % 16) * 16 + m_acc / 16;
            13: m_acc = 255 - m_acc;
            14: begin r = m_acc + 1; m_c = (r > 255); m_acc = r % 256; end
            15: begin m_halt = 1; next_pc = m_pc; end
            default: ;
        endcase
        if (op inside {1, 2, 3, 4, 6, 7, 8, 12, 13, 14}) m_z = (m_acc == 0);
        m_pc = next_pc;
    endtask

    // One clock: model reacts to the edge, then returns at the following negedge.
    task automatic tick(input bit pulse);
        @(posedge clk);
        if (ena) begin
            case (mode)
                2'b01: begin
                    if (m_prev != 2'b01) m_wp = 0;
                    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0;
                    if (pulse) begin
                        m_mem[m_wp] = ui_in;
                        m_wp = (m_wp + 1) % 16;
                    end
                end
                2'b10: if (!m_halt) m_exec();
                2'b11: if (pulse && !m_halt) m_exec();
                default: ;
            endcase
            m_prev = mode;
        end
        @(negedge clk);
    endtask

    task automatic check(input string tag);
        logic [7:0] exp_st;
        exp_st = {4'b0, m_halt, m_z, m_c, (mode == 2'b10) && !m_halt};
        checks++;
        assert (uo_out === 8'(m_out)) else begin
            failures++;
            $error("FAIL %s uo_out got %02h exp %02h", tag, uo_out, 8'(m_out));
        end
        checks++;
        assert (uio_out === exp_st) else begin
            failures++;
            $error("FAIL %s uio_out got %02h exp %02h", tag, uio_out, exp_st);
        end
        checks++;
        assert (uio_oe === 8'h0F) else begin
            failures++;
            $error("FAIL %s uio_oe got %02h exp 0f", tag, uio_oe);
        end
    endtask

    task automatic expect_lit(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got %02h exp %02h", tag, got, exp);
        end
    endtask

    // Action lands on the third rising edge after the strobe rises.
    task automatic do_strobe();
        strobe = 1'b1;
        tick(0); tick(0); tick(1); tick(0);
        strobe = 1'b0;
        repeat (4) tick(0);
    endtask

    task automatic load_word(input logic [63:0] w, input int n);
        mode = 2'b01;
        tick(0);
        for (int i = 0; i < n; i++) begin
            ui_in = w[8*(n-1-i) +: 8];
            do_strobe();
        end
        mode = 2'b00;
        tick(0);
    endtask

    task automatic run(input int n, input string tag);
        mode = 2'b10;
        for (int i = 0; i < n; i++) begin
            tick(0);
            check(tag);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode = 2'b00;
        strobe = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        m_reset();
        do_reset();
        check("reset");
        expect_lit("reset_uo", uo_out, 8'h00);
        expect_lit("reset_uio", uio_out, 8'h00);
        expect_lit("reset_oe", uio_oe, 8'h0F);

        // LDI 5, ADDI 3, OUT, HLT
        load_word(64'h152350F0, 4);
        run(10, "basic");
        expect_lit("basic_uo", uo_out, 8'h08);
        expect_lit("basic_uio", uio_out, 8'h08);

        // 0xFF + 0xF carries out to 0x0E
        load_word(64'h1F8F2F50F0, 5);
        run(10, "carry");
        expect_lit("carry_uo", uo_out, 8'h0E);
        expect_lit("carry_uio", uio_out, 8'h0A);

        // Countdown loop from 3
        load_word(64'h135031A591F0, 6);
        run(2, "loop");
        expect_lit("loop_3", uo_out, 8'h03);
        run(4, "loop");
        expect_lit("loop_2", uo_out, 8'h02);
        run(4, "loop");
        expect_lit("loop_1", uo_out, 8'h01);
        run(10, "loop");
        expect_lit("loop_end_uo", uo_out, 8'h01);
        expect_lit("loop_end_uio", uio_out, 8'h0C);

        // IN / OUT / HLT single-stepped
        do_reset();
        load_word(64'h4050F0, 3);
        ui_in = 8'hA5;
        mode = 2'b11;
        tick(0);
        do_strobe();
        check("step1");
        expect_lit("step1_uo", uo_out, 8'h00);
        do_strobe();
        check("step2");
        expect_lit("step2_uo", uo_out, 8'hA5);
        do_strobe();
        check("step3");
        expect_lit("step3_uio", uio_out, 8'h08);

        // INC, OUT, JMP 0 loops forever; ena=0 must freeze it
        do_reset();
        load_word(64'hE05090, 3);
        run(7, "ena_pre");
        expect_lit("ena_pre_uo", uo_out, 8'h02);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(0);
            check("ena_off");
        end
        expect_lit("ena_off_uo", uo_out, 8'h02);
        ena = 1'b1;
        run(3, "ena_on");
        expect_lit("ena_on_uo", uo_out, 8'h03);

        // Asynchronous reset mid-run wipes memory as well
        run(5, "pre_rst");
        #2 rst_n = 1'b0;
        m_reset();
        #1 check("rst_async");
        expect_lit("rst_async_uo", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(20, "post_rst");
        expect_lit("post_rst_uo", uo_out, 8'h00);
        expect_lit("post_rst_uio", uio_out, 8'h01);

        // Random programs, including pointer wrap and RUN/STEP switching
        for (int it = 0; it < 12; it++) begin
            mode = 2'b01;
            tick(0);
            n = 16 + int'($urandom_range(0, 2));
            for (int i = 0; i < n; i++) begin
                ui_in = 8'($urandom);
                do_strobe();
            end
            ui_in = 8'($urandom);
            mode = 2'b00;
            tick(0);
            check("rnd_idle");
            run(int'($urandom_range(5, 40)), "rnd_run");
            mode = 2'b11;
            tick(0);
            for (int s = 0; s < 2; s++) begin
                do_strobe();
                check("rnd_step");
            end
            run(3, "rnd_resume");
            mode = 2'b00;
            tick(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
